// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-addressed little-endian data memory behind a
// req/ready/valid handshake with LATENCY cycles from accept to response.
// Handles byte, halfword and word accesses, and sign- or zero-extends reads.
// An access that is too wide or runs past DEPTH returns err=1, rdata=0 and
// performs no write.
//
// Optional build macro DATA_MEMORY_CTRL_ALIGN_CHECK_EN: when defined, an
// access whose address is not a multiple of its width also returns err=1.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset (memory contents are kept)
//   req       request, sampled only while ready=1
//   we        1 = write, 0 = read
//   size      access width is 2^size bytes
//   sign_ext  reads only: 1 = sign-extend, 0 = zero-extend
//   addr      byte address of the lowest byte
//   wdata     write data; the low 2^size bytes are used
//   ready     idle; a request is accepted on this edge if req=1
//   valid     one-cycle response strobe
//   rdata     read result, held until the next response (0 for writes/errors)
//   err       error flag of the current response, qualified by valid
//   dbg_addr  debug byte address
//   dbg_byte  combinational byte at dbg_addr, 0 when out of range
module data_memory_ctrl #(
  parameter int WORD_BYTES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int LATENCY    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req,
  input  logic                    we,
  input  logic [1:0]              size,
  input  logic                    sign_ext,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [WORD_BYTES*8-1:0] wdata,
  output logic                    ready,
  output logic                    valid,
  output logic [WORD_BYTES*8-1:0] rdata,
  output logic                    err,
  input  logic [ADDR_WIDTH-1:0]   dbg_addr,
  output logic [7:0]              dbg_byte
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic                    accept, access;

  logic                    we_q, sext_q;
  logic [1:0]              size_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [WORD_BYTES*8-1:0] wdata_q;

  logic [7:0]              mem [DEPTH];

  logic [3:0]              nb;
  logic [ADDR_WIDTH:0]     last_addr;
  logic                    acc_err;
  logic                    sbit;
  logic [IW-1:0]           top_idx;
  logic [WORD_BYTES*8-1:0] rd_n;

  // Access decode on the latched request. The end address is formed one bit
  // wider than addr so a request near the top of the address space cannot
  // wrap around into range.
  always_comb begin
    nb        = 4'd1 << size_q;
    last_addr = {1'b0, addr_q} + (ADDR_WIDTH+1)'(nb) - (ADDR_WIDTH+1)'(1);
    acc_err   = (32'(nb) > WORD_BYTES) || (last_addr >= DEPTH_X);
`ifdef DATA_MEMORY_CTRL_ALIGN_CHECK_EN
    if ((addr_q & (ADDR_WIDTH'(nb) - ADDR_WIDTH'(1))) != '0) acc_err = 1'b1;
`endif
  end

  // Read assembly: low bytes from memory, upper bytes filled with the MSB of
  // the topmost byte read (or zero). Index truncation is harmless because the
  // result is discarded whenever the range check fails.
  always_comb begin
    top_idx = IW'(last_addr);
    sbit    = sext_q & mem[top_idx][7];
    rd_n    = '0;
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      if (i < 32'(nb)) rd_n[8*i +: 8] = mem[IW'(addr_q + ADDR_WIDTH'(i))];
      else             rd_n[8*i +: 8] = {8{sbit}};
    end
    if (acc_err) rd_n = '0;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    access  = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          cnt_n   = CW'(LATENCY - 1);
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          access  = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign ready = (state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      valid   <= 1'b0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      valid <= access;
      if (accept) begin
        we_q    <= we;
        sext_q  <= sign_ext;
        size_q  <= size;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (access) begin
        rdata <= we_q ? '0 : rd_n;
        err   <= acc_err;
      end
    end
  end

  // Storage is not reset. access is derived from the async-reset state, so a
  // reset during BUSY suppresses the pending write.
  always_ff @(posedge clk) begin
    if (access && we_q && !acc_err) begin
      for (int unsigned i = 0; i < WORD_BYTES; i++) begin
        if (i < 32'(nb)) mem[IW'(addr_q + ADDR_WIDTH'(i))] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign dbg_byte = ({1'b0, dbg_addr} < DEPTH_X) ? mem[IW'(dbg_addr)] : 8'h00;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: two instances (LATENCY=2 and LATENCY=1) share
// one stimulus stream; a transaction-level model checks both every cycle,
// and directed transactions pin literal expectations on the LATENCY=2 one.
module tb_data_memory_ctrl;

  localparam int NI  = 2;
  localparam int DEP = 16;
`ifdef DATA_MEMORY_CTRL_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0, we = 1'b0, sign_ext = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [31:0] addr = '0, wdata = '0, dbg_addr = '0;
  logic        rdy [NI];
  logic        vld [NI];
  logic        er  [NI];
  logic [31:0] rd  [NI];
  logic [7:0]  dbg [NI];

  always #5 clk = ~clk;

  data_memory_ctrl #(.WORD_BYTES(4), .ADDR_WIDTH(32), .DEPTH(DEP), .LATENCY(2)) dut0 (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .ready(rdy[0]), .valid(vld[0]), .rdata(rd[0]),
    .err(er[0]), .dbg_addr(dbg_addr), .dbg_byte(dbg[0]));

  data_memory_ctrl #(.WORD_BYTES(4), .ADDR_WIDTH(32), .DEPTH(DEP), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .ready(rdy[1]), .valid(vld[1]), .rdata(rd[1]),
    .err(er[1]), .dbg_addr(dbg_addr), .dbg_byte(dbg[1]));

  // ---------------- reference model ----------------
  int          lat [NI] = '{2, 1};
  logic [7:0]  mm    [NI][DEP];
  bit          known [NI][DEP];
  bit          pend [NI];
  longint      due  [NI];
  bit          p_we [NI], p_sx [NI];
  int          p_n  [NI];
  longint      p_a  [NI];
  logic [31:0] p_wd [NI];
  bit          ev [NI], eer [NI], rd_def [NI];
  logic [31:0] erd [NI];
  longint      edges = 0;
  int          nerr = 0, nchk = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_err(input longint a, input int n);
    return (n > 4) || (a + n - 1 >= DEP) || (ALIGN && (a % n != 0));
  endfunction

  function automatic logic [31:0] m_read(input int k, input longint a, input int n, input bit sx);
    longint v = 0;
    for (int i = 0; i < n; i++) v += longint'(mm[k][a+i]) << (8*i);
    if (sx && n < 4 && mm[k][a+n-1][7]) v += (longint'(1) << 32) - (longint'(1) << (8*n));
    return v[31:0];
  endfunction

  task automatic model_step(input int k);
    if (reset) begin
      pend[k] = 0; ev[k] = 0; eer[k] = 0; erd[k] = '0; rd_def[k] = 1;
      return;
    end
    ev[k] = 0;
    if (pend[k]) begin
      if (edges == due[k]) begin
        pend[k] = 0;
        ev[k]   = 1;
        eer[k]  = m_err(p_a[k], p_n[k]);
        if (eer[k]) begin
          erd[k] = '0; rd_def[k] = 1;
        end else if (p_we[k]) begin
          for (int i = 0; i < p_n[k]; i++) begin
            mm[k][p_a[k]+i]    = 8'(p_wd[k] >> (8*i));
            known[k][p_a[k]+i] = 1;
          end
          rd_def[k] = 0;
        end else begin
          erd[k]    = m_read(k, p_a[k], p_n[k], p_sx[k]);
          rd_def[k] = 1;
          for (int i = 0; i < p_n[k]; i++) if (!known[k][p_a[k]+i]) rd_def[k] = 0;
        end
      end
    end else if (req) begin
      pend[k] = 1;
      due[k]  = edges + lat[k];
      p_we[k] = we;
      p_sx[k] = sign_ext;
      p_n[k]  = 1 << size;
      p_a[k]  = longint'(addr);
      p_wd[k] = wdata;
    end
  endtask

  task automatic compare(input int k);
    chk($sformatf("ready%0d", k), 32'(rdy[k]), 32'(!pend[k]));
    chk($sformatf("valid%0d", k), 32'(vld[k]), 32'(ev[k]));
    if (ev[k]) chk($sformatf("err%0d", k), 32'(er[k]), 32'(eer[k]));
    if (rd_def[k]) chk($sformatf("rdata%0d", k), rd[k], erd[k]);
    if (dbg_addr >= DEP) chk($sformatf("dbg_oor%0d", k), 32'(dbg[k]), 32'h0);
    else if (known[k][int'(dbg_addr)])
      chk($sformatf("dbg%0d", k), 32'(dbg[k]), 32'(mm[k][int'(dbg_addr)]));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      edges++;
      for (int k = 0; k < NI; k++) model_step(k);
      #1;
      for (int k = 0; k < NI; k++) compare(k);
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_both_ready();
    int t = 0;
    @(negedge clk);
    while (!(rdy[0] && rdy[1]) && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!(rdy[0] && rdy[1])) begin
      nchk++; nerr++;
      $display("FAIL ready_timeout: got ready=%b/%b expected 1/1", rdy[0], rdy[1]);
    end
  endtask

  task automatic issue(input bit w, input logic [1:0] s, input bit sx,
                       input logic [31:0] a, input logic [31:0] d);
    wait_both_ready();
    we = w; size = s; sign_ext = sx; addr = a; wdata = d; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  // Directed transaction with literal expectations on the LATENCY=2 instance.
  task automatic txn(input string nm, input bit w, input logic [1:0] s, input bit sx,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input bit exp_err, input bit chk_rd);
    int n = 0;
    issue(w, s, sx, a, d);
    do begin
      @(posedge clk); #2;
      n++;
    end while (!vld[0] && n <= 8);
    chk({nm, "_lat"}, 32'(n), 32'd2);
    chk({nm, "_err"}, 32'(er[0]), 32'(exp_err));
    if (chk_rd) chk({nm, "_rdata"}, rd[0], exp_rd);
  endtask

  task automatic dbg_word(input string nm, input logic [31:0] base, input logic [31:0] exp);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = base + 32'(i);
      #1;
      chk($sformatf("%s_dbg%0d", nm, i), 32'(dbg[0]), 32'(exp[8*i +: 8]));
    end
  endtask

  logic [31:0] iv [4];
  logic [31:0] tmp;
  logic [5:0]  pat;

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(rdy[0]), 32'd1);
    chk("rst_valid", 32'(vld[0]), 32'd0);
    chk("rst_rdata", rd[0], 32'h0);
    chk("rst_err",   32'(er[0]), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      iv[i] = $urandom;
      txn("init", 1'b1, 2'd2, 1'b0, 32'(4*i), iv[i], 32'h0, 1'b0, 1'b0);
    end

    txn("wr_word", 1'b1, 2'd2, 1'b0, 32'd4, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    dbg_word("deadbeef", 32'd4, 32'hDEADBEEF);

    txn("rd_b_sx", 1'b0, 2'd0, 1'b1, 32'd7, 32'h0, 32'hFFFFFFDE, 1'b0, 1'b1);
    txn("rd_b_zx", 1'b0, 2'd0, 1'b0, 32'd7, 32'h0, 32'h000000DE, 1'b0, 1'b1);
    txn("rd_h_sx", 1'b0, 2'd1, 1'b1, 32'd4, 32'h0, 32'hFFFFBEEF, 1'b0, 1'b1);

    txn("wr_h_mis", 1'b1, 2'd1, 1'b0, 32'd5, 32'h00001234, 32'h0, ALIGN, 1'b0);
    txn("rd_w_4", 1'b0, 2'd2, 1'b0, 32'd4, 32'h0,
        ALIGN ? 32'hDEADBEEF : 32'hDE1234EF, 1'b0, 1'b1);

    txn("wr_w_14", 1'b1, 2'd2, 1'b0, 32'd14, $urandom, 32'h0, 1'b1, 1'b1);
    tmp = iv[3];
    dbg_addr = 32'd14; #1; chk("mem14_kept", 32'(dbg[0]), 32'(tmp[23:16]));
    dbg_addr = 32'd15; #1; chk("mem15_kept", 32'(dbg[0]), 32'(tmp[31:24]));
    dbg_addr = 32'd16; #1; chk("dbg_oor",    32'(dbg[0]), 32'h0);

    txn("rd_size3", 1'b0, 2'd3, 1'b0, 32'd0, 32'h0, 32'h0, 1'b1, 1'b1);
    txn("rd_b_15",  1'b0, 2'd0, 1'b0, 32'd15, 32'h0, 32'(tmp[31:24]), 1'b0, 1'b1);
    txn("rd_h_15",  1'b0, 2'd1, 1'b0, 32'd15, 32'h0, 32'h0, 1'b1, 1'b1);
    txn("rd_w_top", 1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0, 32'h0, 1'b1, 1'b1);

    // Reset one cycle into a BUSY write aborts it on both instances.
    issue(1'b1, 2'd2, 1'b0, 32'd0, 32'hCAFEF00D);
    reset = 1'b1;
    #1;
    chk("abort_ready0", 32'(rdy[0]), 32'd1);
    chk("abort_ready1", 32'(rdy[1]), 32'd1);
    chk("abort_valid0", 32'(vld[0]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dbg_word("abort", 32'd0, iv[0]);
    txn("rd_w_0", 1'b0, 2'd2, 1'b0, 32'd0, 32'h0, iv[0], 1'b0, 1'b1);

    // Back-to-back reads with req held: LATENCY=1 instance responds every 2 cycles.
    wait_both_ready();
    we = 1'b0; size = 2'd2; sign_ext = 1'b0; addr = 32'd8; req = 1'b1;
    pat = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      pat[c] = vld[1];
      addr = 32'(4 * (c % 4));
    end
    req = 1'b0;
    chk("b2b_pattern", 32'(pat), 32'h2A);

    // Randomised traffic, including out-of-range, oversize and occasional resets.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      reset    = ($urandom_range(0, 99) == 0);
      req      = ($urandom_range(0, 9) < 7);
      we       = $urandom_range(0, 1);
      size     = 2'($urandom_range(0, 3));
      sign_ext = $urandom_range(0, 1);
      addr     = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFF - 32'($urandom_range(0, 3))
                                              : 32'($urandom_range(0, 17));
      wdata    = $urandom;
      dbg_addr = 32'($urandom_range(0, 19));
    end
    @(negedge clk);
    reset = 1'b0;
    req   = 1'b0;
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
